// File: rtl/i2c_seq_pkg.sv
// Shared definitions for the I2C transaction sequencer: state codes,
// the transaction record and the fixed register-write table.
package i2c_seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_FETCH = 4'd1,
        ST_ADDR  = 4'd2,
        ST_REG   = 4'd3,
        ST_DATA  = 4'd4,
        ST_WAIT  = 4'd5,
        ST_ABORT = 4'd6,
        ST_GAP   = 4'd7,
        ST_DONE  = 4'd8,
        ST_ERROR = 4'd9
    } state_t;

    typedef struct packed {
        logic [7:0] dev_addr;
        logic [7:0] reg_addr;
        logic [7:0] data;
    } txn_t;

    // Sensor init list; entries beyond NUM_TXN are never visited.
    localparam txn_t TXN_TABLE [0:15] = '{
        {8'hEE, 8'hF4, 8'h27},
        {8'hEE, 8'hF5, 8'hA0},
        {8'hEE, 8'hE0, 8'hB6},
        {8'hEE, 8'hF2, 8'h01},
        {8'hEE, 8'h00, 8'h00},
        {8'hEE, 8'h00, 8'h00},
        {8'hEE, 8'h00, 8'h00},
        {8'hEE, 8'h00, 8'h00},
        {8'hEE, 8'h00, 8'h00},
        {8'hEE, 8'h00, 8'h00},
        {8'hEE, 8'h00, 8'h00},
        {8'hEE, 8'h00, 8'h00},
        {8'hEE, 8'h00, 8'h00},
        {8'hEE, 8'h00, 8'h00},
        {8'hEE, 8'h00, 8'h00},
        {8'hEE, 8'h00, 8'h00}
    };

endpackage

// File: rtl/i2c_txn_rom.sv
// Registered read of the transaction table. The output only updates when
// en is high, so it doubles as the holding register for the current entry.
module i2c_txn_rom
    import i2c_seq_pkg::*;
(
    input  logic       clk,
    input  logic       en,
    input  logic [3:0] idx,
    output txn_t       entry
);

    // Capture the addressed entry; held until the next fetch
    always_ff @(posedge clk) begin
        if (en) begin
            entry <= TXN_TABLE[idx];
        end
    end

endmodule

// File: rtl/i2c_txn_sequencer.sv
// I2C transaction sequencer: walks TXN_TABLE issuing byte commands to the
// bit engine, one ACK/NACK response per command, with abort and bounded retry.
// Optional feature macro: I2C_GAP_EN (idle gap of GAP_CYCLES between entries).
module i2c_txn_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int NUM_TXN    = 4,
    parameter int MAX_RETRY  = 2
`ifdef I2C_GAP_EN
    ,
    parameter int GAP_CYCLES = 1000
`endif
) (
    input  logic       FPGA_CLK1_50,
    input  logic       reset,
    input  logic       go,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic       cmd_start,
    output logic       cmd_stop,
    output logic       cmd_stop_only,
    output logic [7:0] cmd_byte,
    input  logic       rsp_valid,
    input  logic       rsp_ack,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [3:0] err_index,
    output logic [7:0] state_dbg
);

    state_t     state, state_nxt;
    state_t     phase;
    logic [3:0] idx;
    logic [2:0] retry_cnt;
    logic       abort_sent;
    txn_t       cur;

    logic xfer, idle_like, start_run, last_entry, retry_ok;
    logic data_ok, abort_rsp;

    assign xfer       = cmd_valid && cmd_ready;
    assign idle_like  = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR);
    assign start_run  = idle_like && go;
    assign last_entry = (idx == 4'(NUM_TXN - 1));
    assign retry_ok   = (retry_cnt < 3'(MAX_RETRY));
    assign data_ok    = (state == ST_WAIT) && rsp_valid && rsp_ack && (phase == ST_DATA);
    assign abort_rsp  = (state == ST_ABORT) && abort_sent && rsp_valid;

    i2c_txn_rom u_rom (
        .clk   (FPGA_CLK1_50),
        .en    (state == ST_FETCH),
        .idx   (idx),
        .entry (cur)
    );

`ifdef I2C_GAP_EN
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    logic [GAP_W-1:0] gap_cnt;
    logic             gap_last;
    assign gap_last = (gap_cnt == GAP_W'(GAP_CYCLES - 1));

    // Count cycles spent in GAP; cleared whenever we are elsewhere
    always_ff @(posedge FPGA_CLK1_50) begin
        if (reset || state != ST_GAP) gap_cnt <= '0;
        else                          gap_cnt <= gap_cnt + GAP_W'(1);
    end
`endif

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: if (go) state_nxt = ST_FETCH;
            ST_FETCH:                   state_nxt = ST_ADDR;
            ST_ADDR, ST_REG, ST_DATA:   if (xfer) state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (rsp_valid) begin
                    if (!rsp_ack)                state_nxt = ST_ABORT;
                    else if (phase == ST_ADDR)   state_nxt = ST_REG;
                    else if (phase == ST_REG)    state_nxt = ST_DATA;
                    else if (last_entry)         state_nxt = ST_DONE;
                    else begin
`ifdef I2C_GAP_EN
                        state_nxt = ST_GAP;
`else
                        state_nxt = ST_FETCH;
`endif
                    end
                end
            end
            ST_ABORT:                   if (abort_rsp) state_nxt = retry_ok ? ST_FETCH : ST_ERROR;
`ifdef I2C_GAP_EN
            ST_GAP:                     if (gap_last) state_nxt = ST_FETCH;
`endif
            default:                    state_nxt = ST_IDLE;
        endcase
    end

    // State, table index, retry count and sticky status
    always_ff @(posedge FPGA_CLK1_50) begin
        if (reset) begin
            state      <= ST_IDLE;
            phase      <= ST_ADDR;
            idx        <= '0;
            retry_cnt  <= '0;
            abort_sent <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            err_index  <= '0;
        end else begin
            state      <= state_nxt;
            abort_sent <= (state == ST_ABORT) && (abort_sent || xfer);
            if ((state == ST_ADDR || state == ST_REG || state == ST_DATA) && xfer) begin
                phase <= state;
            end
            if (start_run) begin
                idx       <= '0;
                retry_cnt <= '0;
                done      <= 1'b0;
                error     <= 1'b0;
            end
            if (data_ok) begin
                retry_cnt <= '0;
                if (last_entry) done <= 1'b1;
                else            idx  <= idx + 4'd1;
            end
            if (abort_rsp) begin
                if (retry_ok) begin
                    retry_cnt <= retry_cnt + 3'd1;
                end else begin
                    error     <= 1'b1;
                    err_index <= idx;
                end
            end
        end
    end

    // Command payload decoded from the registered state and held entry
    always_comb begin
        cmd_valid     = 1'b0;
        cmd_start     = 1'b0;
        cmd_stop      = 1'b0;
        cmd_stop_only = 1'b0;
        cmd_byte      = 8'h00;
        case (state)
            ST_ADDR: begin
                cmd_valid = 1'b1;
                cmd_start = 1'b1;
                cmd_byte  = cur.dev_addr & 8'hFE;
            end
            ST_REG: begin
                cmd_valid = 1'b1;
                cmd_byte  = cur.reg_addr;
            end
            ST_DATA: begin
                cmd_valid = 1'b1;
                cmd_stop  = 1'b1;
                cmd_byte  = cur.data;
            end
            ST_ABORT: begin
                cmd_valid     = !abort_sent;
                cmd_stop      = !abort_sent;
                cmd_stop_only = !abort_sent;
            end
            default: ;
        endcase
    end

    assign busy      = !idle_like;
    assign state_dbg = {4'b0000, state};

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Self-checking bench for i2c_txn_sequencer: a bit-engine responder driven
// by an ACK plan, compared against a transaction-level model of the run.
module tb_i2c_txn_sequencer;

    localparam int NTXN = 2;
    localparam int MAXR = 2;
`ifdef I2C_GAP_EN
    localparam int GAPN = 10;
`else
    localparam int GAPN = 0;
`endif
    localparam logic [10:0] STOPCMD = {3'b011, 8'h00};

    logic       clk = 1'b0;
    logic       reset, go, cmd_ready, rsp_valid, rsp_ack;
    logic       cmd_valid, cmd_start, cmd_stop, cmd_stop_only, busy, done, error;
    logic [7:0] cmd_byte, state_dbg;
    logic [3:0] err_index;

    int          n_tests = 0;
    int          n_fail  = 0;
    bit          plan [64];
    logic [10:0] obs_q [$];
    logic [10:0] exp_q [$];
    bit          exp_done, exp_err;
    int          exp_eidx;

    always #10 clk = ~clk;

    i2c_txn_sequencer #(
        .NUM_TXN   (NTXN),
        .MAX_RETRY (MAXR)
`ifdef I2C_GAP_EN
        ,
        .GAP_CYCLES(GAPN)
`endif
    ) dut (
        .FPGA_CLK1_50 (clk),
        .reset        (reset),
        .go           (go),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_start    (cmd_start),
        .cmd_stop     (cmd_stop),
        .cmd_stop_only(cmd_stop_only),
        .cmd_byte     (cmd_byte),
        .rsp_valid    (rsp_valid),
        .rsp_ack      (rsp_ack),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .err_index    (err_index),
        .state_dbg    (state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected command {start, stop, stop_only, byte} for entry e, phase ph
    function automatic logic [10:0] mk(input int e, input int ph);
        case (ph)
            0:       return {3'b100, 8'hEE};
            1:       return {3'b000, (e == 0) ? 8'hF4 : 8'hF5};
            default: return {3'b010, (e == 0) ? 8'h27 : 8'hA0};
        endcase
    endfunction

    // Transaction-level model: replay the ACK plan against the table rules
    task automatic build_model();
        int  k, tries;
        bit  ok;
        k = 0;
        exp_q.delete();
        exp_err  = 0;
        exp_eidx = 0;
        for (int e = 0; e < NTXN && !exp_err; e++) begin
            tries = 0;
            ok    = 0;
            while (!ok && !exp_err) begin
                ok = 1;
                for (int ph = 0; ph < 3 && ok; ph++) begin
                    exp_q.push_back(mk(e, ph));
                    if (!plan[k]) ok = 0;
                    k++;
                end
                if (!ok) begin
                    exp_q.push_back(STOPCMD);
                    k++;
                    if (tries == MAXR) begin
                        exp_err  = 1;
                        exp_eidx = e;
                    end else begin
                        tries++;
                    end
                end
            end
        end
        exp_done = !exp_err;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_valid"}, cmd_valid, 0);
        check({tag, "_start"}, cmd_start, 0);
        check({tag, "_stop"}, cmd_stop, 0);
        check({tag, "_stoponly"}, cmd_stop_only, 0);
        check({tag, "_byte"}, cmd_byte, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_eidx"}, err_index, 0);
        check({tag, "_state"}, state_dbg, 0);
    endtask

    task automatic pulse_go();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        check("go_busy", busy, 1);
        check("go_fetch", state_dbg, 1);
        check("go_valid0", cmd_valid, 0);
        check("go_clr_done", done, 0);
        check("go_clr_err", error, 0);
        @(negedge clk);
        check("lat_valid", cmd_valid, 1);
        check("lat_addr", state_dbg, 2);
    endtask

    task automatic run_seq(input int rdy_min, input int rdy_max, input bit noise);
        int          guard, k, gcnt;
        logic [10:0] c;
        bit          stable;
        guard = 0;
        k     = 0;
        obs_q.delete();
        pulse_go();
        while (busy && guard < 20000) begin
            if (cmd_valid) begin
                c      = {cmd_start, cmd_stop, cmd_stop_only, cmd_byte};
                stable = 1;
                repeat ($urandom_range(rdy_max, rdy_min)) begin
                    if (noise && $urandom_range(0, 3) == 0) begin rsp_valid = 1; rsp_ack = 0; end
                    if (noise && $urandom_range(0, 7) == 0) go = 1;
                    @(negedge clk);
                    guard++;
                    rsp_valid = 0;
                    go        = 0;
                    if (!cmd_valid || {cmd_start, cmd_stop, cmd_stop_only, cmd_byte} != c) stable = 0;
                end
                check("stable", stable, 1);
                cmd_ready = 1;
                if (noise && $urandom_range(0, 1) == 1) begin rsp_valid = 1; rsp_ack = 0; end
                @(negedge clk);
                guard++;
                cmd_ready = 0;
                rsp_valid = 0;
                obs_q.push_back(c);
                check("one_xfer", cmd_valid, 0);
                repeat ($urandom_range(3, 0)) begin @(negedge clk); guard++; end
                rsp_valid = 1;
                rsp_ack   = plan[k];
                @(negedge clk);
                guard++;
                rsp_valid = 0;
                rsp_ack   = 0;
                if (c == mk(0, 2) && plan[k]) begin
                    gcnt = 0;
                    while (state_dbg == 8'd7 && gcnt < GAPN + 5) begin
                        go = noise && (gcnt == 0);
                        @(negedge clk);
                        go = 0;
                        gcnt++;
                        guard++;
                    end
                    check("gap_len", gcnt, GAPN);
                    check("gap_to_fetch", state_dbg, 1);
                end
                k++;
            end else begin
                @(negedge clk);
                guard++;
            end
        end
        if (guard >= 20000) check("timeout", 1, 0);
        build_model();
        check("n_cmds", obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("cmd%0d", i), obs_q[i], exp_q[i]);
        end
        check("end_done", done, exp_done);
        check("end_error", error, exp_err);
        if (exp_err) check("end_eidx", err_index, exp_eidx);
        check("end_state", state_dbg, exp_err ? 8'd9 : 8'd8);
        check("end_busy", busy, 0);
        check("end_valid", cmd_valid, 0);
    endtask

    initial begin
        reset     = 1;
        go        = 0;
        cmd_ready = 0;
        rsp_valid = 0;
        rsp_ack   = 0;
        repeat (3) @(negedge clk);
        reset = 0;
        @(negedge clk);
        check_reset_vals("rst");

        // all ACK, fast engine
        foreach (plan[i]) plan[i] = 1;
        run_seq(0, 0, 0);
        // all ACK, engine stalls 20 cycles on every command
        run_seq(20, 20, 0);
        // NACK on the first ADDR only
        foreach (plan[i]) plan[i] = 1;
        plan[0] = 0;
        run_seq(0, 2, 1);
        // NACK on every ADDR: retries exhausted at entry 0
        foreach (plan[i]) plan[i] = 0;
        run_seq(0, 3, 0);
        // entry 0 succeeds, entry 1 always NACKs
        foreach (plan[i]) plan[i] = (i < 3);
        run_seq(0, 1, 1);

        // reset while waiting for the REG response
        foreach (plan[i]) plan[i] = 1;
        pulse_go();
        cmd_ready = 1;
        @(negedge clk);
        cmd_ready = 0;
        rsp_valid = 1;
        rsp_ack   = 1;
        @(negedge clk);
        rsp_valid = 0;
        check("mid_reg", state_dbg, 3);
        cmd_ready = 1;
        @(negedge clk);
        cmd_ready = 0;
        check("mid_wait", state_dbg, 5);
        reset = 1;
        @(negedge clk);
        reset = 0;
        check_reset_vals("midrst");
        run_seq(0, 1, 0);

        // randomized ACK plans with stray responses and go pulses
        for (int r = 0; r < 10; r++) begin
            foreach (plan[i]) plan[i] = ($urandom_range(0, 3) != 0);
            run_seq(0, 3, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
